// File: rtl/reg_file_alu_src_pkg.sv
// Shared definitions for the ALU operand-source stage and the ALU itself:
// default widths, the hardwired-zero register index and flag-vector bit positions.
package reg_file_alu_src_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int R0_IDX     = 0;

   localparam int FLAG_W  = 2;
   localparam int FLAG_OF = 1;
   localparam int FLAG_ZF = 0;

   function automatic logic [FLAG_W-1:0] pack_flags(input logic of_bit, input logic zf_bit);
      logic [FLAG_W-1:0] f;
      f          = '0;
      f[FLAG_OF] = of_bit;
      f[FLAG_ZF] = zf_bit;
      return f;
   endfunction
endpackage

// File: rtl/reg_file_alu_src_flag_reg.sv
// Two-bit enabled flag register with synchronous active-high reset.
module flag_reg
   import reg_file_alu_src_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [FLAG_W-1:0] d,
   output logic [FLAG_W-1:0] q
);
   logic [FLAG_W-1:0] flags_reg;

   always_ff @(posedge clk) begin
      if (rst)
         flags_reg <= '0;
      else if (en)
         flags_reg <= d;
   end

   assign q = flags_reg;
endmodule

// File: rtl/reg_file_alu_src.sv
// ALU operand-source stage: 2R/1W register file with r0 hardwired to zero, plus OF/ZF flag register.
// Optional write-to-read forwarding is enabled by defining REG_BYPASS_EN.
module reg_file_alu_src
   import reg_file_alu_src_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] R_Addr_A,
   input  logic [ADDR_W-1:0] R_Addr_B,
   input  logic [ADDR_W-1:0] W_Addr,
   input  logic              Write_Reg,
   input  logic [DATA_W-1:0] W_Data,
   output logic [DATA_W-1:0] R_Data_A,
   output logic [DATA_W-1:0] R_Data_B,
   input  logic              flag_we,
   input  logic              OF_in,
   input  logic              ZF_in,
   output logic              OF,
   output logic              ZF
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(R0_IDX);

   logic [DATA_W-1:0] regs_reg [0:DEPTH-1];
   logic              wr_en;
   logic [FLAG_W-1:0] flags_q;

   assign wr_en = Write_Reg && !rst && (W_Addr != R0_ADDR);

   // Entry 0 is only ever cleared, so it stays zero without a special read case.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            regs_reg[i] <= '0;
      end else if (wr_en) begin
         regs_reg[W_Addr] <= W_Data;
      end
   end

   always_comb begin
      R_Data_A = (R_Addr_A == R0_ADDR) ? '0 : regs_reg[R_Addr_A];
      R_Data_B = (R_Addr_B == R0_ADDR) ? '0 : regs_reg[R_Addr_B];
`ifdef REG_BYPASS_EN
      if (wr_en && (W_Addr == R_Addr_A))
         R_Data_A = W_Data;
      if (wr_en && (W_Addr == R_Addr_B))
         R_Data_B = W_Data;
`endif
   end

   flag_reg u_flag_reg (
      .clk (clk),
      .rst (rst),
      .en  (flag_we),
      .d   (pack_flags(OF_in, ZF_in)),
      .q   (flags_q)
   );

   assign OF = flags_q[FLAG_OF];
   assign ZF = flags_q[FLAG_ZF];
endmodule
